// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: setup, group lookahead, sum/flags stages.
// Latency: 3 clocks from acceptance to out_valid; throughput 1 result per clock.
// Backpressure: out_valid && !out_ready freezes every stage and drops in_ready.
//
// Ports:
//   clk, rst_n              rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready     operand handshake (in_ready = !out_valid || out_ready)
//   a, b, cin, sub          operands; sub=1 computes a-b and ignores cin
//   out_valid / out_ready   result handshake
//   sum, cout, ovf, zero    registered result and flags (cout=1 on sub means no borrow)
module pipelined_cla_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NGRP = WIDTH / GROUP;

  // One global advance: either every stage moves or every stage holds.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // ---------------- stage 1: propagate/generate setup ----------------
  logic [WIDTH-1:0] beff;
  assign beff = sub ? ~b : b;

  logic             s1_vld;
  logic [WIDTH-1:0] s1_p, s1_g;
  logic             s1_c0, s1_amsb, s1_bmsb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_p    <= '0;
      s1_g    <= '0;
      s1_c0   <= 1'b0;
      s1_amsb <= 1'b0;
      s1_bmsb <= 1'b0;
    end else if (adv) begin
      // A cycle without a handshake loads a bubble rather than holding.
      s1_vld  <= in_valid;
      s1_p    <= a ^ beff;
      s1_g    <= a & beff;
      s1_c0   <= sub ? 1'b1 : cin;
      s1_amsb <= a[WIDTH-1];
      s1_bmsb <= beff[WIDTH-1];
    end
  end

  // ---------------- stage 2: group lookahead ----------------
  logic [WIDTH:0] c_la;

  always_comb begin
    logic [NGRP:0]   gc;
    logic [NGRP-1:0] gp, gg;
    logic            t, pre;
    c_la = '0;
    gc   = '0;
    gp   = '0;
    gg   = '0;
    t    = 1'b0;
    pre  = 1'b0;

    // Group propagate/generate, then group carries rippled from c0.
    gc[0] = s1_c0;
    for (int j = 0; j < NGRP; j++) begin
      gp[j] = 1'b1;
      gg[j] = 1'b0;
      for (int k = 0; k < GROUP; k++) begin
        gg[j] = s1_g[j*GROUP+k] | (s1_p[j*GROUP+k] & gg[j]);
        gp[j] = gp[j] & s1_p[j*GROUP+k];
      end
      gc[j+1] = gg[j] | (gp[j] & gc[j]);
    end

    // Bit carries inside a group use the fully expanded sum-of-products
    // from the group carry-in, so no bit waits on its neighbour.
    for (int j = 0; j < NGRP; j++) begin
      c_la[j*GROUP] = gc[j];
      for (int k = 1; k < GROUP; k++) begin
        t = gc[j];
        for (int n = 0; n < k; n++) t = t & s1_p[j*GROUP+n];
        for (int m = 0; m < k; m++) begin
          pre = s1_g[j*GROUP+m];
          for (int n = m + 1; n < k; n++) pre = pre & s1_p[j*GROUP+n];
          t = t | pre;
        end
        c_la[j*GROUP+k] = t;
      end
    end
    c_la[WIDTH] = gc[NGRP];
  end

  logic             s2_vld;
  logic [WIDTH-1:0] s2_p;
  logic [WIDTH:0]   s2_c;
  logic             s2_amsb, s2_bmsb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld  <= 1'b0;
      s2_p    <= '0;
      s2_c    <= '0;
      s2_amsb <= 1'b0;
      s2_bmsb <= 1'b0;
    end else if (adv) begin
      s2_vld  <= s1_vld;
      s2_p    <= s1_p;
      s2_c    <= c_la;
      s2_amsb <= s1_amsb;
      s2_bmsb <= s1_bmsb;
    end
  end

  // ---------------- stage 3: sum and flags ----------------
  logic [WIDTH-1:0] sum_nxt;
  assign sum_nxt = s2_p ^ s2_c[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else if (adv) begin
      out_valid <= s2_vld;
      // Result registers only change on a real result, so a bubble
      // leaves the last value visible.
      if (s2_vld) begin
        sum  <= sum_nxt;
        cout <= s2_c[WIDTH];
        // Operands of equal sign producing a result of the other sign;
        // identical to carry-into-MSB xor carry-out-of-MSB.
        ovf  <= (s2_amsb == s2_bmsb) && (sum_nxt[WIDTH-1] != s2_amsb);
        zero <= (sum_nxt == '0);
      end
    end
  end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
module tb_pipelined_cla_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, out_ready, sub, cin;
  logic [31:0] a_w, b_w;

  logic        rdy16, ov16, co16, of16, z16;
  logic [15:0] s16;
  logic        rdy8, ov8, co8, of8, z8;
  logic [7:0]  s8;
  logic        rdy32, ov32, co32, of32, z32;
  logic [31:0] s32;

  pipelined_cla_adder #(.WIDTH(16), .GROUP(4)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy16),
    .a(a_w[15:0]), .b(b_w[15:0]), .cin(cin), .sub(sub),
    .out_valid(ov16), .out_ready(out_ready),
    .sum(s16), .cout(co16), .ovf(of16), .zero(z16));

  pipelined_cla_adder #(.WIDTH(8), .GROUP(2)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy8),
    .a(a_w[7:0]), .b(b_w[7:0]), .cin(cin), .sub(sub),
    .out_valid(ov8), .out_ready(out_ready),
    .sum(s8), .cout(co8), .ovf(of8), .zero(z8));

  pipelined_cla_adder #(.WIDTH(32), .GROUP(8)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32),
    .a(a_w), .b(b_w), .cin(cin), .sub(sub),
    .out_valid(ov32), .out_ready(out_ready),
    .sum(s32), .cout(co32), .ovf(of32), .zero(z32));

  // Result records: {zero, ovf, cout, sum zero-extended to 32 bits}.
  logic [34:0] r16, r8, r32;
  assign r16 = {z16, of16, co16, 16'd0, s16};
  assign r8  = {z8,  of8,  co8,  24'd0, s8};
  assign r32 = {z32, of32, co32, s32};

  int n_cmp  = 0;
  int n_fail = 0;
  int n_recv16 = 0;
  logic [34:0] q16[$], q8[$], q32[$];

  task automatic chk(input string nm, input logic [34:0] act, input logic [34:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Behavioural reference: plain integer arithmetic, signed range check for ovf.
  function automatic logic [34:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic sb_sub, input logic c_in);
    longint unsigned m, aa, bb, s, full;
    longint sa, sbv, r, hi, lo;
    logic co, ov;
    m  = (64'd1 << w) - 64'd1;
    aa = {32'd0, a} & m;
    bb = {32'd0, b} & m;
    full = 64'd0;
    if (sb_sub) begin
      s  = (aa - bb) & m;
      co = (aa >= bb);
    end else begin
      full = aa + bb + {63'd0, c_in};
      s    = full & m;
      co   = (full >> w) != 64'd0;
    end
    sa  = $signed(aa);
    sbv = $signed(bb);
    if (aa > (m >> 1)) sa  = sa  - $signed(m) - 64'sd1;
    if (bb > (m >> 1)) sbv = sbv - $signed(m) - 64'sd1;
    r  = sb_sub ? (sa - sbv) : (sa + sbv + $signed({63'd0, c_in}));
    hi = $signed(m >> 1);
    lo = -hi - 64'sd1;
    ov = (r > hi) || (r < lo);
    return {(s == 64'd0), ov, co, s[31:0]};
  endfunction

  // Scoreboard: handshakes are decided by the values held across the next
  // rising edge, so sample them on the falling edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (in_valid && rdy16) q16.push_back(model(16, a_w, b_w, sub, cin));
      if (in_valid && rdy8)  q8.push_back(model(8, a_w, b_w, sub, cin));
      if (in_valid && rdy32) q32.push_back(model(32, a_w, b_w, sub, cin));
      if (ov16 && out_ready) begin
        if (q16.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL extra16: result %h with no pending operand", r16);
        end else begin
          chk("res16", r16, q16.pop_front());
          n_recv16++;
        end
      end
      if (ov8 && out_ready) begin
        if (q8.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL extra8: result %h with no pending operand", r8);
        end else chk("res8", r8, q8.pop_front());
      end
      if (ov32 && out_ready) begin
        if (q32.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL extra32: result %h with no pending operand", r32);
        end else chk("res32", r32, q32.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        sub;
    logic        cin;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  initial begin
    vec_t        tbl[10];
    logic [15:0] sa[8], sbv[8];
    logic [34:0] hold;
    int          i, n, recv0;

    //            sub   cin   a         b         sum       cout  ovf   zero
    tbl[0] = '{1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 16'h1234, 16'h4321, 16'h5556, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 16'h5555, 16'h5555, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{1'b1, 1'b0, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    tbl[9] = '{1'b1, 1'b0, 16'h7FFF, 16'hFFFF, 16'h8000, 1'b0, 1'b1, 1'b0};

    // ---------- reset state ----------
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    sub = 1'b0; cin = 1'b0; a_w = '0; b_w = '0;
    #3;
    chk("reset_out", {ov16, r16}, 36'd0);
    #9 rst_n = 1'b1;
    #1 chk("reset_in_ready", {34'd0, rdy16}, 35'd1);
    @(posedge clk); #1;

    // ---------- directed vectors with latency check ----------
    for (int v = 0; v < 10; v++) begin
      a_w = {16'd0, tbl[v].a}; b_w = {16'd0, tbl[v].b};
      sub = tbl[v].sub; cin = tbl[v].cin;
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 1;
      while (!ov16 && n < 8) begin
        @(posedge clk); #1;
        n++;
      end
      chk($sformatf("latency%0d", v), 35'(n), 35'd3);
      chk($sformatf("vec%0d", v), r16,
          {tbl[v].zero, tbl[v].ovf, tbl[v].cout, 16'd0, tbl[v].sum});
    end
    @(posedge clk); #1;

    // ---------- back-to-back stream with a 3-cycle stall ----------
    for (int k = 0; k < 8; k++) begin
      sa[k]  = 16'($urandom);
      sbv[k] = 16'($urandom);
    end
    recv0 = n_recv16;
    sub = 1'b0; cin = 1'b0;
    i = 0;
    hold = '0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      out_ready = !(cyc >= 5 && cyc <= 7);
      in_valid  = (i < 8);
      if (i < 8) begin
        a_w = {16'd0, sa[i]};
        b_w = {16'd0, sbv[i]};
      end
      @(negedge clk);
      if (cyc >= 5 && cyc <= 7) begin
        chk($sformatf("stall_in_ready%0d", cyc), {34'd0, rdy16}, 35'd0);
        if (cyc == 5) hold = r16;
        else chk($sformatf("stall_hold%0d", cyc), {ov16, r16}, {1'b1, hold});
      end
      if (in_valid && rdy16) i++;
      @(posedge clk); #1;
      if (i == 8 && q16.size() == 0) break;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stream_count", 35'(n_recv16 - recv0), 35'd8);

    // ---------- asynchronous reset with work in flight ----------
    for (int k = 0; k < 3; k++) begin
      a_w = 32'h0100 + 32'(k); b_w = 32'h0010; sub = 1'b0; cin = 1'b0;
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("pre_reset_valid", {34'd0, ov16}, 35'd1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", {ov16, r16}, 36'd0);
    q16.delete(); q8.delete(); q32.delete();
    #2 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("no_stale%0d", k), {33'd0, ov16, rdy16}, 35'd1);
    end
    @(posedge clk); #1;

    // ---------- random sweep over all three configurations ----------
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a_w = $urandom; b_w = $urandom;
      if ($urandom_range(0, 7) == 0) a_w = 32'hFFFF_FFFF;
      if ($urandom_range(0, 7) == 0) b_w = 32'h8000_8080;
      sub = 1'($urandom_range(0, 1));
      cin = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
    end
    chk("drain16", 35'(q16.size()), 35'd0);
    chk("drain8",  35'(q8.size()),  35'd0);
    chk("drain32", 35'(q32.size()), 35'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor built from per-bit propagate/generate setup, group lookahead and sum stages.
- Registers each stage and moves operands through a valid/ready handshake, so it can sit between registered datapath blocks in the ALU.
- Adds add/sub mode, carry-in, carry-out, signed overflow and zero flags.

Parameters:
WIDTH, 16, operand and result width in bits; WIDTH >= 2 and a multiple of GROUP.
GROUP, 4, bits per lookahead group; legal values are 2, 4 and 8.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands are presented this cycle
in_ready  output  1  block accepts operands this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in; ignored when sub=1
sub  input  1  0 selects A+B+cin; 1 selects A-B
out_valid  output  1  result is valid
out_ready  input  1  consumer accepts the result this cycle
sum  output  WIDTH  result
cout  output  1  carry out of the MSB; for sub, 1 means no borrow
ovf  output  1  two's-complement signed overflow
zero  output  1  sum == 0

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits, out_valid, sum, cout, ovf and zero clear to 0. in_ready reads 1 once rst_n is high. Any transaction in flight is discarded, with no partial output.
- Global advance: adv = !out_valid || out_ready, and in_ready = adv. When adv is 1, every stage register loads from the stage before it. When adv is 0, all stages hold.
- Accept: an operand is taken when in_valid && in_ready. Otherwise stage 1 loads with its valid bit = 0, so bubbles propagate and do not collapse.
- Stage 1 (setup):
  - beff = sub ? ~b : b; c0 = sub ? 1 : cin.
  - Per bit: p[i] = a[i]^beff[i], g[i] = a[i]&beff[i].
  - Registers p, g, c0, a[MSB], beff[MSB].
- Stage 2 (lookahead):
  - Per group: GP = AND of p, GG = prefix-generate of the group.
  - Group carries are rippled across groups from c0.
  - Bit carries inside each group come from lookahead (c[i+1] = g[i] | p[i]&c[i], expanded).
  - Registers p, carry vector c[WIDTH:0], and the MSB operand bits.
- Stage 3 (sum/flags):
  - sum = p ^ c[WIDTH-1:0]; cout = c[WIDTH].
  - ovf = c[WIDTH] ^ c[WIDTH-1]; zero = (sum == 0).
  - out_valid = stage-2 valid.
- Latency: exactly 3 clocks from acceptance to out_valid when out_ready is held high. Throughput is 1 result per clock.
- Backpressure: out_valid && !out_ready freezes the whole pipeline, including in_ready = 0.
  - sum, cout, ovf and zero stay stable while stalled.
  - No transaction is dropped or duplicated.
- Simultaneous accept and drain: when out_ready = 1 and out_valid = 1, a new operand is accepted in the same cycle.
- Outputs are registered and have no combinational path from a/b to sum. in_ready depends combinationally on out_ready only.
- Results are modulo 2^WIDTH. The carry chain wraps nowhere.

Test Plan:
1. Reset mid-stream: with 3 transactions in flight, pulse rst_n low asynchronously between clock edges → out_valid = 0 and sum = 0 immediately. No stale result appears after rst_n rises.
2. WIDTH=16, sub=0, a=0xFFFF, b=0x0001, cin=0 → 3 clocks later: sum=0x0000, cout=1, ovf=0, zero=1.
3. sub=0, a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, ovf=1, zero=0. Then sub=1, a=0x8000, b=0x0001 → sum=0x7FFF, cout=1, ovf=1.
4. sub=1, a=0x0003, b=0x0005, cin=1 (ignored) → sum=0xFFFE, cout=0, ovf=0.
5. Back-to-back stream of 8 random pairs with out_ready held low for cycles 5-7 → in_ready=0 during the stall and outputs hold. All 8 results arrive in order and match a+b reference; no loss or duplication.
6. Random sweep over WIDTH=8/GROUP=2, WIDTH=32/GROUP=8 and WIDTH=16/GROUP=4, with random in_valid/out_ready → every result matches the behavioural model for sum, cout, ovf and zero.
